rd_addr_stream: RTL and testbench
=================================

# rd_addr_stream

Read-side companion to the write address generator: tracks words the writer has committed into a MAX_DATA-deep circular synchronous RAM and issues matching wrapping read addresses. It absorbs the RAM's one-cycle read latency and presents the data as a valid/ready stream. It sits between the shared buffer RAM and downstream consumers, so the buffer behaves as a FIFO.

## Interface
- MAX_DATA, 256, buffer depth in words; must match the writer's MAX_DATA
- DWIDTH, 8, data word width
- AWIDTH, $clog2(MAX_DATA), local, address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  writer committed one word this cycle, at the writer's current address
- mem_rd_en  out  1  RAM read strobe
- mem_raddr  out  AWIDTH  RAM read address
- mem_rdata  in  DWIDTH  RAM read data, valid the cycle after mem_rd_en
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts this cycle
- out_data  out  DWIDTH  stream data
- count  out  AWIDTH+1  words written but not yet read from RAM
- empty  out  1  count==0, no read in flight, output buffer empty
- overflow  out  1  sticky: writer overran unread data

## Operation
- Reset values: raddr=0, count=0, inflight=0, output buffer empty, out_valid=0, mem_rd_en=0, out_data=0, empty=1, overflow=0.
- pop = out_valid & out_ready.
- Issue condition: mem_rd_en = (count!=0) & (buf_cnt + inflight - pop <= 1). The signal is combinational from registered state and out_ready. buf_cnt ranges 0..2; inflight ranges 0..1.
- On issue: raddr advances by 1 and wraps from MAX_DATA-1 to 0, the same sequence the writer uses. inflight is set to 1 for the next cycle.
- count update: +1 on wr_en only, -1 on issue only, unchanged when both occur.
- Overflow: if wr_en occurs with count==MAX_DATA and no issue that cycle:
  - overflow is set and held until rst;
  - count saturates at MAX_DATA;
  - raddr is unchanged.
- Capture: when inflight==1, mem_rdata is written into the output buffer at the end of that cycle.
- Output buffer: 2-entry FIFO.
  - out_data is the head entry.
  - out_valid = buf_cnt!=0.
  - A capture and a pop in the same cycle are both performed.
- out_data holds its value while out_valid & !out_ready.
- The credit check guarantees the buffer never overflows.

## Timing
- Latency: wr_en in cycle 0 → mem_rd_en in cycle 1 → mem_rdata in cycle 2 → out_valid in cycle 3.
- Throughput is 1 word/cycle sustained while out_ready=1 and count>0.
- Back-pressure: if out_ready stays low, at most 2 words are buffered. After that, mem_rd_en stays low until a pop.
- Reset mid-operation clears all state immediately. RAM data for a read issued before rst is discarded.
- With MAX_DATA not a power of two, raddr must still wrap at MAX_DATA-1, never at 2^AWIDTH-1.
- count==MAX_DATA is representable because count is AWIDTH+1 bits wide.

## Structure
- Shared package holds:
  - the address-width function (clog2 of depth);
  - the wrap-increment function next_addr(addr, MAX_DATA);
  - both are used by this block and the writer, so their sequences match by construction.
- One sub-module: skid_fifo2, a parameterised DWIDTH 2-entry FIFO with push/pop/count.
- Credit logic, counters and overflow stay in the top level.

## Test plan
- Single word: MAX_DATA=8, RAM preloaded; one wr_en at cycle 0 → mem_rd_en at cycle 1 with raddr=0, out_valid at cycle 3 with RAM[0], empty=1 after the pop.
- Streaming: 20 consecutive wr_en, out_ready=1, MAX_DATA=8.
  - Expect 20 words in order at 1/cycle.
  - raddr sequence is 0..7,0..7,0..3.
  - No bubbles after the first output.
- Back-pressure: 5 writes with out_ready=0.
  - Expect exactly 2 reads issued and count=3.
  - Raise out_ready: the remaining 3 words follow in order, none lost or duplicated.
- Full/overflow: MAX_DATA=8, out_ready=0, 11 writes.
  - count saturates at 8 and overflow=1 after the first overrun.
  - overflow stays 1 across later pops until rst.
- Simultaneous: wr_en coinciding with an issue while count=3 → count remains 3.
- Reset mid-read: assert rst the cycle after mem_rd_en.
  - All outputs return to reset values; no stale word appears on out_data.
  - The next write reads from raddr 0.
- Non-power-of-two MAX_DATA=6: 14 writes → raddr wraps 5→0 each lap.

Source files
------------

// File: rtl/rd_addr_stream_pkg.sv
// rtl/rd_addr_stream_pkg.sv - address helpers shared by the buffer writer and reader
package rd_addr_stream_pkg;

  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Wraps at depth-1 rather than at a power of two, so odd depths stay in range.
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
    return (addr >= depth - 1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/rd_addr_stream_skid_fifo2.sv
// rtl/rd_addr_stream_skid_fifo2.sv - two-entry FIFO holding RAM read data until consumed
module skid_fifo2 #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop)
        r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_cnt;

endmodule

// File: rtl/rd_addr_stream.sv
// rtl/rd_addr_stream.sv - issues wrapping RAM reads for committed words and streams the data out
module rd_addr_stream
  import rd_addr_stream_pkg::*;
#(
  parameter int  MAX_DATA = 256,
  parameter int  DWIDTH   = 8,
  localparam int AWIDTH   = addr_width(MAX_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  output logic              mem_rd_en,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH:0]   count,
  output logic              empty,
  output logic              overflow
);

  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(MAX_DATA);
  localparam logic [AWIDTH:0] ONE  = (AWIDTH+1)'(1);

  logic [AWIDTH-1:0] r_raddr;
  logic [AWIDTH:0]   r_count;
  logic              r_inflight;
  logic              r_overflow;
  logic [1:0]        w_buf_cnt;
  logic [2:0]        w_credit;
  logic              w_pop;
  logic              w_issue;

  assign w_pop    = out_valid & out_ready;
  // Words held plus the one in flight must leave a free slot once this cycle's pop retires.
  assign w_credit = {1'b0, w_buf_cnt} + {2'b00, r_inflight};
  assign w_issue  = (r_count != '0) && (w_credit <= ({2'b00, w_pop} + 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr    <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue)
        r_raddr <= AWIDTH'(next_addr(32'(r_raddr), 32'(MAX_DATA)));
      case ({wr_en, w_issue})
        2'b10: begin
          if (r_count == FULL)
            r_overflow <= 1'b1;
          else
            r_count <= r_count + ONE;
        end
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  skid_fifo2 #(.DWIDTH(DWIDTH)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (mem_rdata),
    .i_pop       (w_pop),
    .o_data      (out_data),
    .o_count     (w_buf_cnt)
  );

  assign mem_rd_en = w_issue;
  assign mem_raddr = r_raddr;
  assign out_valid = (w_buf_cnt != 2'd0);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign empty     = (r_count == '0) & ~r_inflight & ~out_valid;

endmodule

// File: tb/tb_rd_addr_stream.sv
// tb/tb_rd_addr_stream.sv - scoreboard bench for rd_addr_stream at depths 8 and 6
module tb_rd_addr_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] wdata = 8'd0;

  always #5 clk = ~clk;

  logic       rd_en  [2];
  logic [2:0] raddr  [2];
  logic [7:0] rdata  [2];
  logic       ovalid [2];
  logic [7:0] odata  [2];
  logic [3:0] cnt    [2];
  logic       emp    [2];
  logic       ovf    [2];

  rd_addr_stream #(.MAX_DATA(8), .DWIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .wr_en(wr_en),
    .mem_rd_en(rd_en[0]), .mem_raddr(raddr[0]), .mem_rdata(rdata[0]),
    .out_valid(ovalid[0]), .out_ready(out_ready), .out_data(odata[0]),
    .count(cnt[0]), .empty(emp[0]), .overflow(ovf[0])
  );

  rd_addr_stream #(.MAX_DATA(6), .DWIDTH(8)) u_d6 (
    .clk(clk), .rst(rst), .wr_en(wr_en),
    .mem_rd_en(rd_en[1]), .mem_raddr(raddr[1]), .mem_rdata(rdata[1]),
    .out_valid(ovalid[1]), .out_ready(out_ready), .out_data(odata[1]),
    .count(cnt[1]), .empty(emp[1]), .overflow(ovf[1])
  );

  function automatic int maxd(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  // Shared buffer RAM and the writer side, one per DUT depth.
  logic [7:0] ram [2][8];
  int         waddr [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr[0] <= 0;
      waddr[1] <= 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (wr_en) begin
          ram[d][waddr[d]] <= wdata;
          waddr[d] <= (waddr[d] + 1) % maxd(d);
        end
        if (rd_en[d]) rdata[d] <= ram[d][raddr[d]];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit data_chk = 1'b1;
  int exp_ra [2];
  int n_issue [2];
  int n_pop [2];
  int first_pop, last_pop;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Monitor: every read address and every accepted word is checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ovalid[d] && out_ready) begin
          if (d == 0) begin
            if (n_pop[0] == 0) first_pop = cyc;
            last_pop = cyc;
          end
          n_pop[d]++;
          if (data_chk) begin
            if (qsize(d) == 0)
              check($sformatf("unexpected word dut%0d", d), int'(odata[d]), -1);
            else
              check($sformatf("out_data dut%0d", d), int'(odata[d]), int'(qpop(d)));
          end
        end
        if (rd_en[d]) begin
          check($sformatf("mem_raddr dut%0d", d), int'(raddr[d]), exp_ra[d]);
          exp_ra[d] = (exp_ra[d] + 1) % maxd(d);
          n_issue[d]++;
          check($sformatf("buffer credit dut%0d", d), int'((n_issue[d] - n_pop[d]) <= 2), 1);
        end
      end
    end
  end

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      exp_ra[d] = 0;
      n_issue[d] = 0;
      n_pop[d] = 0;
    end
  endtask

  task automatic step(input bit w, input bit r);
    wr_en = w;
    out_ready = r;
    wdata = 8'($urandom);
    if (w && data_chk) begin
      q0.push_back(wdata);
      q1.push_back(wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s mem_rd_en dut%0d", tag, d), int'(rd_en[d]), 0);
      check($sformatf("%s out_valid dut%0d", tag, d), int'(ovalid[d]), 0);
      check($sformatf("%s out_data dut%0d", tag, d), int'(odata[d]), 0);
      check($sformatf("%s count dut%0d", tag, d), int'(cnt[d]), 0);
      check($sformatf("%s empty dut%0d", tag, d), int'(emp[d]), 1);
      check($sformatf("%s overflow dut%0d", tag, d), int'(ovf[d]), 0);
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60; k++) begin
      if (emp[0] && emp[1] && !ovalid[0] && !ovalid[1]) break;
      step(1'b0, 1'b1);
    end
    check($sformatf("%s drained", tag), int'(emp[0] && emp[1]), 1);
    check($sformatf("%s leftover dut0", tag), q0.size(), 0);
    check($sformatf("%s leftover dut1", tag), q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word latency
    out_ready = 1'b1;
    wr_en = 1'b1;
    wdata = 8'($urandom);
    q0.push_back(wdata);
    q1.push_back(wdata);
    @(negedge clk);
    check("latency c0 mem_rd_en", int'(rd_en[0]), 0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("latency c1 mem_rd_en", int'(rd_en[0]), 1);
    @(negedge clk);
    check("latency c2 out_valid", int'(ovalid[0]), 0);
    @(negedge clk);
    check("latency c3 out_valid", int'(ovalid[0]), 1);
    @(negedge clk);
    check("latency empty after pop", int'(emp[0]), 1);
    @(posedge clk);
    #1;

    // Streaming: 20 back-to-back words, no bubbles once output starts
    for (int d = 0; d < 2; d++) begin n_pop[d] = 0; n_issue[d] = 0; end
    repeat (20) step(1'b1, 1'b1);
    drain("stream");
    check("stream pops", n_pop[0], 20);
    check("stream issues dut0", n_issue[0], 20);
    check("stream issues dut1", n_issue[1], 20);
    check("stream bubble-free span", last_pop - first_pop, 19);

    // Back-pressure, then a write that coincides with an issue
    for (int d = 0; d < 2; d++) n_issue[d] = 0;
    repeat (5) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    check("bp issues dut0", n_issue[0], 2);
    check("bp issues dut1", n_issue[1], 2);
    check("bp count dut0", int'(cnt[0]), 3);
    check("bp count dut1", int'(cnt[1]), 3);
    check("bp out_valid", int'(ovalid[0]), 1);
    wr_en = 1'b1;
    out_ready = 1'b1;
    wdata = 8'($urandom);
    q0.push_back(wdata);
    q1.push_back(wdata);
    @(negedge clk);
    check("simul issue", int'(rd_en[0]), 1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("simul count dut0", int'(cnt[0]), 3);
    check("simul count dut1", int'(cnt[1]), 3);
    @(posedge clk);
    #1;
    drain("bp");

    // Full and overflow
    do_reset();
    data_chk = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0);
      if (i == 9) begin
        check("at full count dut0", int'(cnt[0]), 8);
        check("at full overflow dut0", int'(ovf[0]), 0);
      end
    end
    check("ovf count dut0", int'(cnt[0]), 8);
    check("ovf flag dut0", int'(ovf[0]), 1);
    check("ovf count dut1", int'(cnt[1]), 6);
    check("ovf flag dut1", int'(ovf[1]), 1);
    repeat (8) step(1'b0, 1'b1);
    check("ovf sticky dut0", int'(ovf[0]), 1);
    check("ovf sticky dut1", int'(ovf[1]), 1);
    do_reset();
    data_chk = 1'b1;
    check("ovf cleared dut0", int'(ovf[0]), 0);
    check("ovf cleared dut1", int'(ovf[1]), 0);

    // Reset the cycle after a read issue
    out_ready = 1'b1;
    wr_en = 1'b1;
    wdata = 8'($urandom);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("pre-reset issue", int'(rd_en[0]), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    check_reset_vals("mid-read reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no stale word", int'(ovalid[0] | ovalid[1]), 0);
      step(1'b0, 1'b1);
    end
    step(1'b1, 1'b1);
    drain("after reset");

    // Randomised traffic, kept below the smaller depth so no data is overrun
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 60) && (q0.size() < 6) && (q1.size() < 6),
           $urandom_range(99) < 60);
    end
    drain("random");
    check("random overflow dut0", int'(ovf[0]), 0);
    check("random overflow dut1", int'(ovf[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
